instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit.sv | 143 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetch with a credit-limited response buffer and a valid/ready decode port.
// A redirect flushes buffered words and drops every response still in flight.
module instr_fetch_unit #(
  parameter int unsigned           WORD_WIDTH = 32,
  parameter logic [WORD_WIDTH-1:0] BOOT_ADDR  = '0,
  parameter int unsigned           FIFO_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  instr_req_o,
  output logic [WORD_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [WORD_WIDTH-1:0] instr_rdata_i,
  input  logic                  branch_i,
  input  logic [WORD_WIDTH-1:0] branch_target_i,
  input  logic                  instr_ready_i,
  output logic                  instr_valid_o,
  output logic [WORD_WIDTH-1:0] instruction_o,
  output logic [WORD_WIDTH-1:0] pc_o
);

  localparam int unsigned           PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned           CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0]        DEPTH_C   = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [WORD_WIDTH-1:0] ADDR_STEP = WORD_WIDTH'(4);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_FLUSH} state_e;

  state_e                  state_q, state_d;
  logic [WORD_WIDTH-1:0]   fetch_addr_q, fetch_addr_d;
  logic [WORD_WIDTH-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]        outstanding_q, outstanding_d;
  logic [CNT_W-1:0]        discard_cnt_q, discard_cnt_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [WORD_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [WORD_WIDTH-1:0]   mem_d [FIFO_DEPTH];

  logic [CNT_W:0]          credit_sum;
  logic                    req;
  logic                    gnt_fire;
  logic                    rv_fire;
  logic                    redirect;
  logic                    push;
  logic                    pop;
  logic [WORD_WIDTH-1:0]   target;
  logic                    unused_tgt_lsb;

  assign unused_tgt_lsb = ^branch_target_i[1:0];

  // Buffered plus in-flight words never exceed the buffer size, so every response has a slot.
  assign credit_sum = {1'b0, count_q} + {1'b0, outstanding_q};
  assign req        = (state_q == ST_RUN) && (credit_sum < DEPTH_C);
  assign gnt_fire   = req && instr_gnt_i;
  assign rv_fire    = instr_rvalid_i && (outstanding_q != '0);
  assign redirect   = branch_i && (state_q != ST_BOOT);
  assign push       = rv_fire && (state_q == ST_RUN) && !redirect;
  assign pop        = (count_q != '0) && instr_ready_i && !redirect;
  assign target     = {branch_target_i[WORD_WIDTH-1:2], 2'b00};

  assign outstanding_d = outstanding_q + CNT_W'(gnt_fire) - CNT_W'(rv_fire);

  always_comb begin
    state_d       = state_q;
    fetch_addr_d  = fetch_addr_q;
    pc_d          = pc_q;
    discard_cnt_d = discard_cnt_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    mem_d         = mem_q;
    count_d       = count_q + CNT_W'(push) - CNT_W'(pop);

    if (gnt_fire) begin
      fetch_addr_d = fetch_addr_q + ADDR_STEP;
    end
    if (push) begin
      mem_d[wr_ptr_q] = instr_rdata_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      pc_d     = pc_q + ADDR_STEP;
    end

    case (state_q)
      ST_BOOT:  state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      ST_FLUSH: begin
        if (rv_fire) begin
          discard_cnt_d = discard_cnt_q - CNT_W'(1);
          if (discard_cnt_q == CNT_W'(1)) begin
            state_d = ST_RUN;
          end
        end
      end
      default:  state_d = ST_BOOT;
    endcase

    // Everything still in flight after this edge belongs to the old stream.
    if (redirect) begin
      fetch_addr_d  = target;
      pc_d          = target;
      count_d       = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      discard_cnt_d = outstanding_d;
      state_d       = (outstanding_d != '0) ? ST_FLUSH : ST_RUN;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_BOOT;
      fetch_addr_q  <= BOOT_ADDR;
      pc_q          <= BOOT_ADDR;
      outstanding_q <= '0;
      discard_cnt_q <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      mem_q         <= '{default: '0};
    end else begin
      state_q       <= state_d;
      fetch_addr_q  <= fetch_addr_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      discard_cnt_q <= discard_cnt_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      mem_q         <= mem_d;
    end
  end

  assign instr_req_o   = req;
  assign instr_addr_o  = fetch_addr_q;
  assign instr_valid_o = (count_q != '0);
  assign instruction_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign pc_o          = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a transaction-level model of the fetch stream.
module tb_instr_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] BOOT  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b0;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        instr_ready_i = 1'b0;
  logic        instr_valid_o;
  logic [31:0] instruction_o;
  logic [31:0] pc_o;

  instr_fetch_unit #(
    .WORD_WIDTH(32),
    .BOOT_ADDR (BOOT),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .branch_i       (branch_i),
    .branch_target_i(branch_target_i),
    .instr_ready_i  (instr_ready_i),
    .instr_valid_o  (instr_valid_o),
    .instruction_o  (instruction_o),
    .pc_o           (pc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    bit          live;
    int          age;
  } pend_t;

  pend_t       pend_q[$];   // granted fetches awaiting a response, oldest first
  logic [31:0] buf_q[$];    // addresses of words the decoder has yet to take
  logic [31:0] m_pc;
  logic [31:0] m_fetch;
  bit          m_boot;
  bit          stray_ok;
  int          n_vec;
  int          n_miss;
  int          gnt_pct, rv_pct, rdy_pct, br_pct;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit rv_ok();
    return (pend_q.size() > 0) && (pend_q[0].age >= 1);
  endfunction

  task automatic model_reset();
    pend_q.delete();
    buf_q.delete();
    m_pc    = BOOT;
    m_fetch = BOOT;
    m_boot  = 1'b1;
  endtask

  task automatic do_reset(input int ncyc);
    rst_i          = 1'b1;
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b0;
    branch_i       = 1'b0;
    instr_ready_i  = 1'b0;
    repeat (ncyc) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    model_reset();
  endtask

  // Called at a falling edge: check outputs, drive one cycle of inputs, advance the model.
  task automatic step_with(input bit g, input bit rv, input bit br, input bit rdy,
                           input logic [31:0] tgt);
    bit          stale;
    bit          exp_req;
    bit          exp_valid;
    bit          has_pend;
    logic [31:0] exp_instr;
    stale = 1'b0;
    foreach (pend_q[i]) if (!pend_q[i].live) stale = 1'b1;
    exp_req   = !m_boot && !stale && (buf_q.size() + pend_q.size() < DEPTH);
    exp_valid = buf_q.size() > 0;
    exp_instr = exp_valid ? mem_word(buf_q[0]) : 32'h0;

    check_eq("req",   32'(instr_req_o),   32'(exp_req));
    check_eq("addr",  instr_addr_o,       m_fetch);
    check_eq("valid", 32'(instr_valid_o), 32'(exp_valid));
    check_eq("instr", instruction_o,      exp_instr);
    check_eq("pc",    pc_o,               m_pc);

    has_pend = pend_q.size() > 0;
    assert (!rv || has_pend || stray_ok) else $error("rvalid driven with nothing outstanding");

    instr_gnt_i     = g;
    instr_rvalid_i  = rv;
    instr_rdata_i   = (rv && has_pend) ? mem_word(pend_q[0].addr) : $urandom;
    branch_i        = br;
    branch_target_i = tgt;
    instr_ready_i   = rdy;

    if (exp_valid && rdy && !br) begin
      void'(buf_q.pop_front());
      m_pc = m_pc + 32'd4;
    end
    if (rv && has_pend) begin
      pend_t e;
      e = pend_q.pop_front();
      if (e.live && !br) buf_q.push_back(e.addr);
    end
    if (exp_req && g) begin
      pend_q.push_back('{m_fetch, 1'b1, 0});
      m_fetch = m_fetch + 32'd4;
    end
    if (br) begin
      foreach (pend_q[i]) pend_q[i].live = 1'b0;
      buf_q.delete();
      m_pc    = {tgt[31:2], 2'b00};
      m_fetch = {tgt[31:2], 2'b00};
    end
    foreach (pend_q[i]) pend_q[i].age++;
    m_boot = 1'b0;

    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic bit roll(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  task automatic run_random(input int n);
    logic [31:0] tgt;
    for (int i = 0; i < n; i++) begin
      tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                     : 32'($urandom_range(32'h3FF));
      step_with(roll(gnt_pct), rv_ok() && roll(rv_pct), !m_boot && roll(br_pct),
                roll(rdy_pct), tgt);
    end
  endtask

  task automatic knobs(input int g, input int rv, input int rdy, input int br);
    gnt_pct = g;
    rv_pct  = rv;
    rdy_pct = rdy;
    br_pct  = br;
  endtask

  initial begin
    n_vec    = 0;
    n_miss   = 0;
    stray_ok = 1'b0;
    model_reset();

    // streaming with an always-granting, fast memory
    do_reset(2);
    knobs(100, 100, 100, 0);
    run_random(30);

    // decoder stalls: buffer fills, requests stop, resume after first pop
    knobs(100, 100, 0, 0);
    run_random(10);
    knobs(100, 100, 100, 0);
    run_random(10);

    // two in flight, redirect to an unaligned target
    knobs(100, 0, 100, 0);
    run_random(4);
    step_with(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0103);
    knobs(100, 100, 0, 0);
    run_random(8);
    knobs(100, 100, 100, 0);
    run_random(6);

    // redirect coinciding with ready and a returning word
    knobs(100, 0, 100, 0);
    run_random(4);
    step_with(1'b0, rv_ok(), 1'b0, 1'b0, 32'h0);
    step_with(1'b1, rv_ok(), 1'b1, 1'b1, 32'h0000_0180);
    knobs(100, 100, 100, 0);
    run_random(8);

    // second redirect while still flushing
    knobs(100, 0, 100, 0);
    run_random(4);
    step_with(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0300);
    step_with(1'b0, rv_ok(), 1'b0, 1'b1, 32'h0);
    step_with(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0200);
    knobs(100, 100, 100, 0);
    run_random(10);

    // randomized mix of grant, response, stall and redirect rates
    for (int c = 0; c < 60; c++) begin
      knobs(int'($urandom_range(20, 100)), int'($urandom_range(20, 100)),
            int'($urandom_range(0, 100)), int'($urandom_range(0, 15)));
      run_random(50);
    end

    // reset with a response in flight; it turns up during the boot cycle
    knobs(100, 0, 0, 0);
    run_random(3);
    do_reset(1);
    stray_ok = 1'b1;
    step_with(1'b1, 1'b1, 1'b0, 1'b1, 32'h0);
    stray_ok = 1'b0;
    knobs(100, 100, 100, 0);
    run_random(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
